// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle fetch/decode/execute/memory/writeback control FSM
// with a mem_ready watchdog that traps into a sticky FAULT state.
module multicycle_control_unit #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] OPCODE,
   input  logic [3:0] FUNCFIELD,
   input  logic       mem_ready,
   output logic       C_IRWrite,
   output logic       C_PCWrite,
   output logic       C_PCWriteCond,
   output logic       C_BranchNE,
   output logic [1:0] C_PCSource,
   output logic       C_IorD,
   output logic       C_MemRead,
   output logic       C_MemWrite,
   output logic       C_MemtoReg,
   output logic       C_RegWrite,
   output logic       C_ALUSrcA,
   output logic [1:0] C_ALUSrcB,
   output logic       C_ExtSel,
   output logic [2:0] C_ALUOp,
   output logic       illegal,
   output logic       fault,
   output logic       instr_done,
   output logic [3:0] state
);
   localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_NAND = 3'b010, ALU_OR = 3'b011;
   localparam logic [2:0] ALU_SHL = 3'b100, ALU_SHR = 3'b101, ALU_SAR = 3'b110;
   typedef enum logic [3:0] {
      S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
      S_SHIFT = 4'd4, S_WB_ALU = 4'd5, S_MEM_ADDR = 4'd6, S_MEM_RD = 4'd7,
      S_MEM_WB = 4'd8, S_MEM_WR = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
      S_FAULT = 4'd15
   } state_t;
   typedef struct packed {
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic [1:0] pc_source;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_sel;
      logic [2:0] alu_op;
      logic       illegal;
      logic       fault;
      logic       instr_done;
      logic [3:0] state;
   } ctl_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wait_st, tmo;
   ctl_t          ctl, ctl_g;
   // Watchdog counts consecutive not-ready cycles; any ready or non-wait state clears it.
   assign wait_st = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
   assign cnt_d   = (wait_st && !mem_ready && MEM_TIMEOUT > 0) ? cnt_q + 1'b1 : '0;
   assign tmo     = (MEM_TIMEOUT > 0) && wait_st && !mem_ready && (cnt_d == CW'(MEM_TIMEOUT));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   always_comb begin
      ctl       = '0;
      ctl.state = state_q;
      state_d   = state_q;
      case (state_q)
         S_FETCH: begin
            ctl.mem_read  = 1'b1;
            ctl.alu_src_b = 2'b01;
            ctl.ir_write  = mem_ready;
            ctl.pc_write  = mem_ready;
            state_d       = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ctl.alu_src_b = 2'b11;
            case (OPCODE)
               4'b1000, 4'b1100, 4'b1011, 4'b1111:                   state_d = S_EXEC_R;
               4'b1001, 4'b1010, 4'b1101, 4'b1110, 4'b0111, 4'b0110: state_d = S_EXEC_I;
               4'b0000:                                              state_d = S_SHIFT;
               4'b0001, 4'b0010:                                     state_d = S_MEM_ADDR;
               4'b0100, 4'b0101:                                     state_d = S_BRANCH;
               default:                                              state_d = S_JUMP;
            endcase
         end
         S_EXEC_R: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_op    = OPCODE == 4'b1100 ? ALU_SUB :
                            OPCODE == 4'b1011 ? ALU_NAND :
                            OPCODE == 4'b1111 ? ALU_OR : ALU_ADD;
            state_d       = S_WB_ALU;
         end
         S_EXEC_I: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = 2'b10;
            ctl.ext_sel   = OPCODE == 4'b1001 || OPCODE == 4'b1101;
            ctl.alu_op    = (OPCODE == 4'b1101 || OPCODE == 4'b1110) ? ALU_SUB :
                            OPCODE == 4'b0111 ? ALU_NAND :
                            OPCODE == 4'b0110 ? ALU_OR : ALU_ADD;
            state_d       = S_WB_ALU;
         end
         S_SHIFT: begin
            ctl.alu_src_a  = 1'b1;
            ctl.alu_op     = FUNCFIELD == 4'b0001 ? ALU_SHL :
                             FUNCFIELD == 4'b0010 ? ALU_SHR :
                             FUNCFIELD == 4'b0011 ? ALU_SAR : ALU_ADD;
            ctl.illegal    = !(FUNCFIELD inside {4'b0001, 4'b0010, 4'b0011});
            ctl.instr_done = ctl.illegal;
            state_d        = ctl.illegal ? S_FETCH : S_WB_ALU;
         end
         S_WB_ALU: begin
            ctl.reg_write  = 1'b1;
            ctl.instr_done = 1'b1;
            state_d        = S_FETCH;
         end
         S_MEM_ADDR: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = 2'b10;
            ctl.ext_sel   = 1'b1;
            state_d       = OPCODE == 4'b0001 ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            ctl.mem_read = 1'b1;
            ctl.iord     = 1'b1;
            state_d      = mem_ready ? S_MEM_WB : S_MEM_RD;
         end
         S_MEM_WB: begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = 1'b1;
            ctl.instr_done = 1'b1;
            state_d        = S_FETCH;
         end
         S_MEM_WR: begin
            ctl.mem_write  = 1'b1;
            ctl.iord       = 1'b1;
            ctl.instr_done = mem_ready;
            state_d        = mem_ready ? S_FETCH : S_MEM_WR;
         end
         S_BRANCH: begin
            ctl.alu_src_a     = 1'b1;
            ctl.alu_op        = ALU_SUB;
            ctl.pc_write_cond = 1'b1;
            ctl.pc_source     = 2'b01;
            ctl.branch_ne     = OPCODE[0];
            ctl.instr_done    = 1'b1;
            state_d           = S_FETCH;
         end
         S_JUMP: begin
            ctl.pc_write   = 1'b1;
            ctl.pc_source  = 2'b10;
            ctl.instr_done = 1'b1;
            state_d        = S_FETCH;
         end
         S_FAULT: ctl.fault = 1'b1;
         default: state_d = S_FAULT;
      endcase
      if (tmo) state_d = S_FAULT;
   end
   // Outputs are forced low while reset is held, even though FETCH would assert MemRead.
   assign ctl_g         = rst_n ? ctl : '0;
   assign C_IRWrite     = ctl_g.ir_write;
   assign C_PCWrite     = ctl_g.pc_write;
   assign C_PCWriteCond = ctl_g.pc_write_cond;
   assign C_BranchNE    = ctl_g.branch_ne;
   assign C_PCSource    = ctl_g.pc_source;
   assign C_IorD        = ctl_g.iord;
   assign C_MemRead     = ctl_g.mem_read;
   assign C_MemWrite    = ctl_g.mem_write;
   assign C_MemtoReg    = ctl_g.mem_to_reg;
   assign C_RegWrite    = ctl_g.reg_write;
   assign C_ALUSrcA     = ctl_g.alu_src_a;
   assign C_ALUSrcB     = ctl_g.alu_src_b;
   assign C_ExtSel      = ctl_g.ext_sel;
   assign C_ALUOp       = ctl_g.alu_op;
   assign illegal       = ctl_g.illegal;
   assign fault         = ctl_g.fault;
   assign instr_done    = ctl_g.instr_done;
   assign state         = ctl_g.state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: drives instructions and random mem_ready, comparing every
// cycle against a model built from per-instruction state sequences and a wait counter.
module tb_multicycle_control_unit;
   localparam int T = 15;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] OPCODE, FUNCFIELD;
   logic       mem_ready;
   logic       C_IRWrite, C_PCWrite, C_PCWriteCond, C_BranchNE, C_IorD, C_MemRead;
   logic       C_MemWrite, C_MemtoReg, C_RegWrite, C_ALUSrcA, C_ExtSel;
   logic [1:0] C_PCSource, C_ALUSrcB;
   logic [2:0] C_ALUOp;
   logic       illegal, fault, instr_done;
   logic [3:0] state;
   logic [24:0] dut_v;
   int checks = 0, errors = 0, done_cnt = 0;
   int cur = 0, wcnt = 0;
   int q[$];
   logic [3:0] nop = 4'd0, nfn = 4'd0;

   multicycle_control_unit #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .OPCODE(OPCODE), .FUNCFIELD(FUNCFIELD), .mem_ready(mem_ready),
      .C_IRWrite(C_IRWrite), .C_PCWrite(C_PCWrite), .C_PCWriteCond(C_PCWriteCond),
      .C_BranchNE(C_BranchNE), .C_PCSource(C_PCSource), .C_IorD(C_IorD), .C_MemRead(C_MemRead),
      .C_MemWrite(C_MemWrite), .C_MemtoReg(C_MemtoReg), .C_RegWrite(C_RegWrite),
      .C_ALUSrcA(C_ALUSrcA), .C_ALUSrcB(C_ALUSrcB), .C_ExtSel(C_ExtSel), .C_ALUOp(C_ALUOp),
      .illegal(illegal), .fault(fault), .instr_done(instr_done), .state(state)
   );

   always #5 clk = ~clk;

   assign dut_v = {C_IRWrite, C_PCWrite, C_PCWriteCond, C_BranchNE, C_PCSource, C_IorD,
                   C_MemRead, C_MemWrite, C_MemtoReg, C_RegWrite, C_ALUSrcA, C_ALUSrcB,
                   C_ExtSel, C_ALUOp, illegal, fault, instr_done, state};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // States visited after FETCH for one instruction.
   function automatic void plan(input logic [3:0] op, input logic [3:0] fn);
      case (op)
         4'd8, 4'd12, 4'd11, 4'd15:               q = '{1, 2, 5};
         4'd9, 4'd10, 4'd13, 4'd14, 4'd7, 4'd6:   q = '{1, 3, 5};
         4'd0:  q = (fn >= 4'd1 && fn <= 4'd3) ? '{1, 4, 5} : '{1, 4};
         4'd1:  q = '{1, 6, 7, 8};
         4'd2:  q = '{1, 6, 9};
         4'd4, 4'd5: q = '{1, 10};
         default: q = '{1, 11};
      endcase
   endfunction

   function automatic logic [24:0] expect_out(input int st, input logic [3:0] op,
                                              input logic [3:0] fn, input logic mr);
      logic ir = 0, pcw = 0, pcc = 0, bne = 0, iord = 0, mrd = 0, mw = 0, m2r = 0, rw = 0;
      logic sa = 0, ext = 0, ill = 0, flt = 0, dn = 0;
      logic [1:0] pcs = 0, sb = 0;
      logic [2:0] alu = 0;
      case (st)
         0:  begin mrd = 1; sb = 2'b01; ir = mr; pcw = mr; end
         1:  sb = 2'b11;
         2:  begin sa = 1; alu = op == 12 ? 3'd1 : op == 11 ? 3'd2 : op == 15 ? 3'd3 : 3'd0; end
         3:  begin
            sa = 1; sb = 2'b10; ext = (op == 9 || op == 13);
            alu = (op == 13 || op == 14) ? 3'd1 : op == 7 ? 3'd2 : op == 6 ? 3'd3 : 3'd0;
         end
         4:  begin
            sa = 1;
            if (fn >= 1 && fn <= 3) alu = 3'd3 + 3'(fn);
            else begin ill = 1; dn = 1; end
         end
         5:  begin rw = 1; dn = 1; end
         6:  begin sa = 1; sb = 2'b10; ext = 1; end
         7:  begin mrd = 1; iord = 1; end
         8:  begin rw = 1; m2r = 1; dn = 1; end
         9:  begin mw = 1; iord = 1; dn = mr; end
         10: begin sa = 1; alu = 3'd1; pcc = 1; pcs = 2'b01; bne = op[0]; dn = 1; end
         11: begin pcw = 1; pcs = 2'b10; dn = 1; end
         15: flt = 1;
         default: ;
      endcase
      return {ir, pcw, pcc, bne, pcs, iord, mrd, mw, m2r, rw, sa, sb, ext, alu, ill, flt, dn, 4'(st)};
   endfunction

   // Called at a negedge: drive, check, advance the model, wait for the next negedge.
   task automatic step(input logic mr);
      mem_ready = mr;
      if (cur == 0) begin
         OPCODE = nop;
         FUNCFIELD = nfn;
      end
      #1;
      chk($sformatf("st%0d_op%h", cur, OPCODE), {7'd0, dut_v}, {7'd0, expect_out(cur, OPCODE, FUNCFIELD, mr)});
      if (instr_done) done_cnt++;
      if (cur == 15) ;
      else if (cur inside {0, 7, 9} && !mr) begin
         wcnt++;
         if (wcnt == T) cur = 15;
      end else begin
         wcnt = 0;
         if (cur == 0) plan(OPCODE, FUNCFIELD);
         cur = q.size() > 0 ? q.pop_front() : 0;
      end
      @(negedge clk);
   endtask

   task automatic run_instr(input logic [3:0] op, input logic [3:0] fn, input int pct);
      int n = 0;
      nop = op;
      nfn = fn;
      step($urandom_range(0, 99) < pct);
      n++;
      while (cur != 0 && cur != 15 && n < 80) begin
         step($urandom_range(0, 99) < pct);
         n++;
      end
      if (n >= 80) chk("instr_bound", 32'(cur), 0);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 chk("rst_async", {7'd0, dut_v}, 0);
      @(negedge clk);
      chk("rst_held", {7'd0, dut_v}, 0);
      rst_n = 1'b1;
      cur = 0;
      wcnt = 0;
      q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      mem_ready = 1'b0;
      OPCODE = 4'd0;
      FUNCFIELD = 4'd0;
      @(negedge clk);
      do_reset();
      // add 0x8B48, zero wait
      nop = 4'h8; nfn = 4'hB; done_cnt = 0;
      repeat (4) step(1'b1);
      chk("add_done_pulses", 32'(done_cnt), 1);
      // lw 0x1BC9, three wait cycles in MEM_RD: eight cycles total
      nop = 4'h1; nfn = 4'hB;
      step(1); step(1); step(1); step(0); step(0); step(0); step(1); step(0);
      chk("lw_len", {28'd0, state}, 0);
      // be then bne
      run_instr(4'h4, 4'hB, 100);
      run_instr(4'h5, 4'hB, 100);
      // shifts, including an undefined function
      run_instr(4'h0, 4'h1, 100);
      run_instr(4'h0, 4'h2, 100);
      run_instr(4'h0, 4'h3, 100);
      done_cnt = 0;
      run_instr(4'h0, 4'h5, 100);
      chk("illegal_done", 32'(done_cnt), 1);
      // random instruction mix with random memory waits
      for (int i = 0; i < 150; i++) run_instr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 70);
      // watchdog in FETCH
      if (cur == 15) do_reset();
      nop = 4'h8;
      repeat (T + 3) step(1'b0);
      repeat (3) step(1'b1);
      chk("fault_sticky", {31'd0, fault}, 1);
      do_reset();
      step(1'b1);
      // watchdog in MEM_RD, and ready on the limit cycle in MEM_WR
      nop = 4'h1;
      step(1); step(1); step(1);
      repeat (T + 1) step(1'b0);
      do_reset();
      nop = 4'h2;
      step(1); step(1); step(1);
      repeat (T - 1) step(1'b0);
      step(1'b1);
      // reset dropped in MEM_WR
      nop = 4'h2;
      step(1); step(1); step(1); step(0);
      do_reset();
      step(1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
